// File: rtl/fetch_pc_unit.sv
// rtl/fetch_pc_unit.sv - fetch-stage program counter with trap/jump redirect and optional return-address stack
// Optional feature: define PC_RETURN_STACK_EN to build the circular return-address stack.
module fetch_pc_unit #(
  parameter int unsigned WIDTH        = 32,
  parameter logic [31:0] RESET_VECTOR = 32'h00003000,
  parameter int unsigned STEP         = 4,
  parameter int unsigned RAS_DEPTH    = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             stall,
  input  logic             jumpEnabled,
  input  logic [1:0]       jumpType,
  input  logic [WIDTH-1:0] jumpOperand,
  input  logic             callEnabled,
  input  logic             trapEnabled,
  input  logic [WIDTH-1:0] trapVector,
  output logic [WIDTH-1:0] value,
  output logic             valueChangedTimes,
  output logic             rasEmpty,
  output logic             rasFull
);

  localparam logic [WIDTH-1:0] RESET_VALUE = WIDTH'(RESET_VECTOR);
  localparam logic [WIDTH-1:0] STEP_W      = WIDTH'(STEP);
  localparam logic [WIDTH-1:0] ALIGN_MASK  = ~(STEP_W - WIDTH'(1));

  localparam logic [1:0] JT_NEAR     = 2'd0;
  localparam logic [1:0] JT_FAR      = 2'd1;
  localparam logic [1:0] JT_RELATIVE = 2'd2;
  localparam logic [1:0] JT_RETURN   = 2'd3;

  logic [WIDTH-1:0] r_value;
  logic             r_toggle;

  logic [WIDTH-1:0] w_seq;
  logic [WIDTH-1:0] w_near;
  logic [WIDTH-1:0] w_rel;
  logic [WIDTH-1:0] w_redirect;
  logic [WIDTH-1:0] w_next;
  logic [WIDTH-1:0] w_ras_top;
  logic             w_ras_hit;

  assign w_seq  = r_value + STEP_W;
  assign w_near = {r_value[WIDTH-1:WIDTH-4], jumpOperand[WIDTH-7:0], 2'b00};
  assign w_rel  = r_value + {jumpOperand[WIDTH-3:0], 2'b00};

  always_comb begin
    w_redirect = jumpOperand;
    case (jumpType)
      JT_NEAR:     w_redirect = w_near;
      JT_FAR:      w_redirect = jumpOperand;
      JT_RELATIVE: w_redirect = w_rel;
      JT_RETURN:   w_redirect = w_ras_hit ? w_ras_top : jumpOperand;
      default:     w_redirect = jumpOperand;
    endcase
  end

  // Trap outranks any jump; every redirect target is forced onto a STEP boundary.
  assign w_next = trapEnabled ? (trapVector & ALIGN_MASK)
                : jumpEnabled ? (w_redirect & ALIGN_MASK)
                : w_seq;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_value  <= RESET_VALUE;
      r_toggle <= 1'b0;
    end else if (!stall) begin
      r_value  <= w_next;
      r_toggle <= ~r_toggle;
    end
  end

  assign value             = r_value;
  assign valueChangedTimes = r_toggle;

`ifdef PC_RETURN_STACK_EN
  localparam int unsigned PW = $clog2(RAS_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(RAS_DEPTH);

  logic [WIDTH-1:0] r_ras [RAS_DEPTH];
  logic [PW-1:0]    r_ptr;
  logic [CW-1:0]    r_count;
  logic             r_empty;
  logic             r_full;

  logic [PW-1:0] w_top_idx;
  logic          w_pop;
  logic          w_push;
  logic          w_wr_en;
  logic [PW-1:0] w_wr_idx;
  logic [PW-1:0] w_ptr_next;
  logic [CW-1:0] w_count_next;

  assign w_top_idx = r_ptr - PW'(1);
  assign w_ras_top = r_ras[w_top_idx];
  assign w_ras_hit = (r_count != '0);
  assign w_pop     = !stall && !trapEnabled && jumpEnabled && (jumpType == JT_RETURN) && w_ras_hit;
  assign w_push    = !stall && !trapEnabled && callEnabled;

  // r_ptr is the next free slot; when full it also addresses the oldest entry.
  always_comb begin
    w_wr_en      = 1'b0;
    w_wr_idx     = r_ptr;
    w_ptr_next   = r_ptr;
    w_count_next = r_count;
    if (w_pop && w_push) begin
      w_wr_en  = 1'b1;
      w_wr_idx = w_top_idx;
    end else if (w_pop) begin
      w_ptr_next   = r_ptr - PW'(1);
      w_count_next = r_count - CW'(1);
    end else if (w_push) begin
      w_wr_en      = 1'b1;
      w_ptr_next   = r_ptr + PW'(1);
      w_count_next = (r_count == DEPTH_C) ? r_count : r_count + CW'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (w_wr_en) begin
      r_ras[w_wr_idx] <= w_seq;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_ptr   <= '0;
      r_count <= '0;
      r_empty <= 1'b1;
      r_full  <= 1'b0;
    end else begin
      r_ptr   <= w_ptr_next;
      r_count <= w_count_next;
      r_empty <= (w_count_next == '0);
      r_full  <= (w_count_next == DEPTH_C);
    end
  end

  assign rasEmpty = r_empty;
  assign rasFull  = r_full;
`else
  logic                        w_unused_call;
  logic [$clog2(RAS_DEPTH):0]  w_unused_depth;

  assign w_unused_call  = callEnabled;
  assign w_unused_depth = '0;
  assign w_ras_hit      = 1'b0;
  assign w_ras_top      = '0;
  assign rasEmpty       = 1'b1;
  assign rasFull        = 1'b0;
`endif

endmodule
